// File: rtl/pci_pkg.sv
// Shared PCI target constants: burst modes, command codes, byte-lane width and a parity helper.
package pci_pkg;

  localparam logic [1:0] MODE_LINEAR = 2'b00;
  localparam logic [1:0] MODE_RSVD1  = 2'b01;
  localparam logic [1:0] MODE_WRAP   = 2'b10;
  localparam logic [1:0] MODE_RSVD3  = 2'b11;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  localparam int BYTE_W = 8;
  localparam int PAR_IN_W = 64;

  // Even parity; callers zero-extend, which leaves the parity unchanged.
  function automatic logic even_parity(input logic [PAR_IN_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/pci_addr_counter.sv
// Burst word pointer: load from the address phase, advance per beat in linear or
// cache-line wrap mode, and flag the end of the buffer.
module pci_addr_counter
  import pci_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int LINE_W = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_add,
  input  logic              advance,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] local_add,
  output logic [ADDR_W-1:0] next_add,
  output logic              beat_ok,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADD  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_W - 1);

  logic [ADDR_W-1:0] add_r;
  logic              done_r;
  logic [ADDR_W-1:0] next_add_s;
  logic              end_s;
  logic              mode_ok_s;

  // Next pointer and end-of-buffer detection for the current mode.
  always_comb begin
    next_add_s = add_r;
    end_s      = 1'b0;
    mode_ok_s  = 1'b0;
    case (mode)
      MODE_LINEAR: begin
        mode_ok_s = 1'b1;
        if (add_r == LAST_ADD) begin
          end_s = 1'b1;
        end else begin
          next_add_s = add_r + ADDR_W'(1);
        end
      end
      MODE_WRAP: begin
        mode_ok_s  = 1'b1;
        next_add_s = (add_r & ~LINE_MASK) | ((add_r + ADDR_W'(1)) & LINE_MASK);
      end
      default: begin
        mode_ok_s = 1'b0;
      end
    endcase
  end

  // A load in the same cycle as a beat wins and the beat is dropped.
  assign beat_ok = advance & ~load & done_r & mode_ok_s;

  // Pointer and Done register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      add_r  <= '0;
      done_r <= 1'b1;
    end else if (load) begin
      add_r  <= load_add;
      done_r <= mode_ok_s;
    end else if (advance && done_r) begin
      if (mode_ok_s) begin
        add_r  <= next_add_s;
        done_r <= ~end_s;
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  assign local_add = add_r;
  assign next_add  = next_add_s;
  assign done      = done_r;

endmodule

// File: rtl/pci_target_buffer.sv
// PCI target data stage: local word memory with byte-masked writes and prefetched reads.
// Optional registered PAR generation is enabled by defining PCI_TARGET_PAR_GEN_EN.
module pci_target_buffer
  import pci_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int LINE_W = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ADDRESS_FF,
  input  logic              rst_gen,
  input  logic              update_add_gen,
  input  logic [1:0]        mode,
  input  logic              EnableWrite,
  input  logic              write_on_bus_ctrl,
  input  logic [DATA_W-1:0] AD_in,
  input  logic [3:0]        CBE_n,
  output logic [DATA_W-1:0] AD_out,
  output logic              AD_oe,
  output logic              PAR,
  output logic              Done,
  output logic [ADDR_W-1:0] local_add
);

  localparam int LANES = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] ad_out_r;
  logic              ad_oe_r;
  logic [ADDR_W-1:0] load_add_s;
  logic [ADDR_W-1:0] next_add_s;
  logic              beat_ok_s;
  logic              wr_beat_s;
  logic              rd_beat_s;
  logic              unused_addr_s;

  assign load_add_s    = ADDRESS_FF[ADDR_W+1:2];
  assign unused_addr_s = ^{ADDRESS_FF[31:ADDR_W+2], ADDRESS_FF[1:0]};

  pci_addr_counter #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (rst_gen),
    .load_add  (load_add_s),
    .advance   (update_add_gen),
    .mode      (mode),
    .local_add (local_add),
    .next_add  (next_add_s),
    .beat_ok   (beat_ok_s),
    .done      (Done)
  );

  assign wr_beat_s = beat_ok_s & EnableWrite;
  assign rd_beat_s = beat_ok_s & write_on_bus_ctrl & ~EnableWrite;

  // Byte-masked storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && wr_beat_s) begin
      for (int b = 0; b < LANES; b++) begin
        if (!CBE_n[b]) begin
          mem_r[local_add][b*BYTE_W +: BYTE_W] <= AD_in[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read data: prefetch on load, fetch the following word on each read beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ad_out_r <= '0;
      ad_oe_r  <= 1'b0;
    end else begin
      ad_oe_r <= write_on_bus_ctrl & ~EnableWrite;
      if (rst_gen) begin
        ad_out_r <= mem_r[load_add_s];
      end else if (rd_beat_s) begin
        ad_out_r <= mem_r[next_add_s];
      end
    end
  end

  assign AD_out = ad_out_r;
  assign AD_oe  = ad_oe_r;

`ifdef PCI_TARGET_PAR_GEN_EN
  logic par_r;

  // PAR trails the data it covers by one cycle, only while the target drove AD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_r <= 1'b0;
    end else if (ad_oe_r) begin
      par_r <= even_parity(PAR_IN_W'({ad_out_r, CBE_n}));
    end else begin
      par_r <= 1'b0;
    end
  end

  assign PAR = par_r;
`else
  assign PAR = 1'b0;
`endif

endmodule

// File: tb/tb_pci_target_buffer.sv
// Directed, table-driven bench for pci_target_buffer plus a hand-written wrap/parity sequence.
module tb_pci_target_buffer;
  import pci_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] ADDRESS_FF;
  logic        rst_gen;
  logic        update_add_gen;
  logic [1:0]  mode;
  logic        EnableWrite;
  logic        write_on_bus_ctrl;
  logic [31:0] AD_in;
  logic [3:0]  CBE_n;
  logic [31:0] AD_out;
  logic        AD_oe;
  logic        PAR;
  logic        Done;
  logic [3:0]  local_add;

  int n_cmp;
  int n_bad;

`ifdef PCI_TARGET_PAR_GEN_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        rst_gen;
    logic        upd;
    logic [1:0]  mode;
    logic        ew;
    logic        wobc;
    logic [31:0] addr;
    logic [31:0] ad_in;
    logic [3:0]  cbe;
    logic [3:0]  exp_add;
    logic        exp_done;
    logic        exp_oe;
    logic [31:0] exp_ad;
    logic        chk_ad;
    logic        chk_par;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  pci_target_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .ADDRESS_FF        (ADDRESS_FF),
    .rst_gen           (rst_gen),
    .update_add_gen    (update_add_gen),
    .mode              (mode),
    .EnableWrite       (EnableWrite),
    .write_on_bus_ctrl (write_on_bus_ctrl),
    .AD_in             (AD_in),
    .CBE_n             (CBE_n),
    .AD_out            (AD_out),
    .AD_oe             (AD_oe),
    .PAR               (PAR),
    .Done              (Done),
    .local_add         (local_add)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rg, input logic up, input logic [1:0] md,
                       input logic ew, input logic wb, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] c);
    rst = r; rst_gen = rg; update_add_gen = up; mode = md;
    EnableWrite = ew; write_on_bus_ctrl = wb; ADDRESS_FF = a; AD_in = d; CBE_n = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //           rst   rg    upd   mode   ew    wobc  addr      ad_in         cbe      add    done  oe    exp_ad        chk_ad chk_par
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'hF,    4'd0,  1'b1, 1'b0, 32'h0,        1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'hF,    4'd0,  1'b1, 1'b0, 32'h0,        1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h400,  32'h0,        4'hF,    4'd0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h400,  32'h11111111, 4'h0,    4'd1,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h400,  32'h22222222, 4'h0,    4'd2,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h400,  32'h33333333, 4'h0,    4'd3,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h4,    32'h0,        4'hF,    4'd1,  1'b1, 1'b0, 32'h22222222, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h4,    32'hFFFFFFFF, 4'b1010, 4'd2,  1'b1, 1'b0, 32'h22222222, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0,    32'h0,        4'h0,    4'd0,  1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0,    32'h0,        4'h0,    4'd1,  1'b1, 1'b1, 32'h22FF22FF, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0,    32'h0,        4'h0,    4'd2,  1'b1, 1'b1, 32'h33333333, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0,    32'h0,        4'h0,    4'd2,  1'b1, 1'b1, 32'h33333333, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'hF,    4'd2,  1'b1, 1'b0, 32'h33333333, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h3C,   32'h0,        4'hF,    4'd15, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h3C,   32'hA5A5A5A5, 4'h0,    4'd15, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h3C,   32'h5A5A5A5A, 4'h0,    4'd15, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h3C,   32'h0,        4'h0,    4'd15, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h3C,   32'h0,        4'h0,    4'd15, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h3C,   32'h0,        4'h0,    4'd15, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0,    32'h0,        4'hF,    4'd0,  1'b0, 1'b0, 32'h11111111, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0,    32'hDEADBEEF, 4'h0,    4'd0,  1'b0, 1'b0, 32'h11111111, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0,    32'h0,        4'h0,    4'd0,  1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 32'h4,    32'h0,        4'h0,    4'd1,  1'b1, 1'b0, 32'h22FF22FF, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 32'h4,    32'h77777777, 4'h0,    4'd2,  1'b1, 1'b0, 32'h22FF22FF, 1'b1, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h4,    32'h0,        4'h0,    4'd1,  1'b1, 1'b1, 32'h77777777, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0,    32'h0,        4'h0,    4'd0,  1'b1, 1'b0, 32'h0,        1'b1, 1'b1};
    vecs[26] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,    32'h0,        4'hF,    4'd0,  1'b1, 1'b0, 32'h0,        1'b1, 1'b1};

    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].rst_gen, vecs[i].upd, vecs[i].mode, vecs[i].ew,
            vecs[i].wobc, vecs[i].addr, vecs[i].ad_in, vecs[i].cbe);
      step();
      check($sformatf("v%0d local_add", i), 32'(local_add), 32'(vecs[i].exp_add));
      check($sformatf("v%0d Done", i), 32'(Done), 32'(vecs[i].exp_done));
      check($sformatf("v%0d AD_oe", i), 32'(AD_oe), 32'(vecs[i].exp_oe));
      if (vecs[i].chk_ad) check($sformatf("v%0d AD_out", i), AD_out, vecs[i].exp_ad);
      if (vecs[i].chk_par) check($sformatf("v%0d PAR", i), 32'(PAR), 32'h0);
    end

    // Cache-line wrap starting at word 2: writes walk 2,3,0,1 and return to 2.
    drive(1'b1, 1'b1, 1'b0, MODE_WRAP, 1'b0, 1'b0, 32'h08, 32'h0, 4'hF);
    step();
    check("wrap load add", 32'(local_add), 32'd2);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, MODE_WRAP, 1'b1, 1'b0, 32'h08, 32'(k + 1), 4'h0);
      step();
      check($sformatf("wrap wr%0d add", k), 32'(local_add), 32'((k + 3) % 4));
      check($sformatf("wrap wr%0d Done", k), 32'(Done), 32'h1);
    end

    // Read the line back; PAR follows AD_out by one cycle.
    drive(1'b1, 1'b1, 1'b0, MODE_WRAP, 1'b0, 1'b1, 32'h08, 32'h0, 4'h0);
    step();
    check("wrap rd prefetch", AD_out, 32'h00000001);
    check("wrap rd oe", 32'(AD_oe), 32'h1);
    drive(1'b1, 1'b0, 1'b0, MODE_WRAP, 1'b0, 1'b1, 32'h08, 32'h0, 4'h0);
    step();
    check("wrap PAR", 32'(PAR), 32'(PAR_ON));
    check("wrap rd hold", AD_out, 32'h00000001);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, MODE_WRAP, 1'b0, 1'b1, 32'h08, 32'h0, 4'h0);
      step();
      check($sformatf("wrap rd%0d data", k), AD_out, 32'(((k + 1) % 4) + 1));
      check($sformatf("wrap rd%0d add", k), 32'(local_add), 32'((k + 3) % 4));
    end
    check("wrap rd Done", 32'(Done), 32'h1);

    drive(1'b1, 1'b0, 1'b0, MODE_LINEAR, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    step();
    step();
    check("idle PAR", 32'(PAR), 32'h0);
    check("idle oe", 32'(AD_oe), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
